floating_point_multiplier_arbiter: RTL and testbench

- Shares one fixed-latency floating point multiplier between NUM_REQ requesters.
- Uses a round-robin grant and issues at most one operand pair per cycle.
- Carries the requester ID alongside the multiplier pipeline in a tag shift register, so each product is steered back to its originator.
- Sits between the per-channel datapaths and a single multiplier instance. The multiplier has no backpressure, so results are never stalled.

---
 rtl/floating_point_multiplier_arbiter_pkg.sv | 20 ++
 rtl/floating_point_multiplier_arbiter_rr.sv | 45 ++++
 rtl/floating_point_multiplier_arbiter.sv | 100 ++++++++++
 tb/tb_floating_point_multiplier_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/floating_point_multiplier_arbiter_pkg.sv
// Shared types and width helpers for the shared floating point multiplier arbiter.
package fp_mul_arb_pkg;

  localparam int MAX_TAG_WIDTH = 8;

  function automatic int fp_width(input int exp_width, input int frac_width);
    return 1 + exp_width + frac_width;
  endfunction

  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Tag field is sized for the largest supported requester count; unused upper bits stay zero.
  typedef struct packed {
    logic                     valid;
    logic [MAX_TAG_WIDTH-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/floating_point_multiplier_arbiter_rr.sv
// Round-robin arbiter: combinational grant search starting at the pointer, pointer owned here.
module round_robin_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int TAG_WIDTH = tag_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 advance,
  output logic [NUM_REQ-1:0]   grant,
  output logic [TAG_WIDTH-1:0] grant_idx
);

  logic [TAG_WIDTH-1:0] ptr;
  logic                 found;
  int                   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = TAG_WIDTH'(cand);
      end
    end
  end

  // The winner moves to lowest priority for the next search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/floating_point_multiplier_arbiter.sv
// Shares one fixed-latency FP multiplier among NUM_REQ requesters, steering each product
// back to its originator through a tag pipe that runs alongside the multiplier.
module floating_point_multiplier_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int EXP_WIDTH   = 8,
  parameter int FRAC_WIDTH  = 23,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2,
  localparam int FP_WIDTH_REG = fp_width(EXP_WIDTH, FRAC_WIDTH),
  localparam int TAG_WIDTH    = tag_width(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*FP_WIDTH_REG-1:0] req_a_i,
  input  logic [NUM_REQ*FP_WIDTH_REG-1:0] req_b_i,
  output logic [FP_WIDTH_REG-1:0]         mul_a_o,
  output logic [FP_WIDTH_REG-1:0]         mul_b_o,
  output logic                            mul_valid_o,
  input  logic [FP_WIDTH_REG-1:0]         mul_fp_i,
  input  logic                            mul_valid_i,
  output logic [FP_WIDTH_REG-1:0]         rsp_fp_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic                            busy_o,
  output logic                            error_o
);

  logic [NUM_REQ-1:0]   grant;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic                 transfer;
  logic [TAG_WIDTH-1:0] issue_tag;
  tag_entry_t           tag_pipe [MUL_LATENCY];
  tag_entry_t           tail;
  logic                 pipe_busy;

  round_robin_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       (req_valid_i),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready_o = grant;
  assign transfer    = |(req_valid_i & grant);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mul_valid_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      issue_tag   <= '0;
    end else begin
      mul_valid_o <= transfer;
      if (transfer) begin
        mul_a_o   <= req_a_i[int'(grant_idx)*FP_WIDTH_REG +: FP_WIDTH_REG];
        mul_b_o   <= req_b_i[int'(grant_idx)*FP_WIDTH_REG +: FP_WIDTH_REG];
        issue_tag <= grant_idx;
      end
    end
  end

  // Entry 0 trails mul_valid_o by one cycle, so the tail lines up with mul_valid_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MUL_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: mul_valid_o, tag: MAX_TAG_WIDTH'(issue_tag)};
      for (int i = 1; i < MUL_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tail = tag_pipe[MUL_LATENCY-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_fp_o    <= '0;
      rsp_valid_o <= '0;
      error_o     <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (mul_valid_i && tail.valid) begin
        rsp_fp_o    <= mul_fp_i;
        rsp_valid_o <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tail.tag;
      end
      if (mul_valid_i != tail.valid) error_o <= 1'b1;
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < MUL_LATENCY; i++) pipe_busy = pipe_busy | tag_pipe[i].valid;
  end

  assign busy_o = mul_valid_o | pipe_busy | (|rsp_valid_o);

endmodule

// File: tb/tb_floating_point_multiplier_arbiter.sv
// Directed scoreboard bench for floating_point_multiplier_arbiter with a behavioural multiplier.
module tb_floating_point_multiplier_arbiter;

  localparam int L  = 2;
  localparam int NR = 4;
  localparam int FW = 32;

  typedef struct {
    int          tag;
    logic [31:0] fp;
  } exp_t;

  logic              clk;
  logic              rst_i;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready_o;
  logic [NR*FW-1:0]  req_a;
  logic [NR*FW-1:0]  req_b;
  logic [FW-1:0]     mul_a_o;
  logic [FW-1:0]     mul_b_o;
  logic              mul_valid_o;
  logic [FW-1:0]     mul_fp_i;
  logic              mul_valid_i;
  logic [FW-1:0]     rsp_fp_o;
  logic [NR-1:0]     rsp_valid_o;
  logic              busy_o;
  logic              error_o;

  logic              inject;
  logic              mm_v [L];
  logic [31:0]       mm_d [L];

  exp_t              q[$];
  int                n_checks;
  int                n_fail;
  int                model_ptr;
  logic              prev_transfer;
  logic [31:0]       prev_a;
  logic [31:0]       prev_b;

  floating_point_multiplier_arbiter #(
    .EXP_WIDTH   (8),
    .FRAC_WIDTH  (23),
    .NUM_REQ     (NR),
    .MUL_LATENCY (L)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_valid_o (mul_valid_o),
    .mul_fp_i    (mul_fp_i),
    .mul_valid_i (mul_valid_i),
    .rsp_fp_o    (rsp_fp_o),
    .rsp_valid_o (rsp_valid_o),
    .busy_o      (busy_o),
    .error_o     (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating single-precision multiply for normal operands.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] f;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      f = p[46:24];
      e = e + 10'd1;
    end else begin
      f = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return NR'(1) << ((p + k) % NR);
    end
    return '0;
  endfunction

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < L; i++) begin
        mm_v[i] <= 1'b0;
        mm_d[i] <= '0;
      end
    end else begin
      mm_v[0] <= mul_valid_o;
      mm_d[0] <= fp_mul(mul_a_o, mul_b_o);
      for (int i = 1; i < L; i++) begin
        mm_v[i] <= mm_v[i-1];
        mm_d[i] <= mm_d[i-1];
      end
    end
  end

  assign mul_valid_i = mm_v[L-1] | inject;
  assign mul_fp_i    = inject ? 32'hDEADBEEF : mm_d[L-1];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : rsp_monitor
    exp_t        e;
    logic [3:0]  oh;
    if (!rst_i && rsp_valid_o !== '0) begin
      if (q.size() == 0) begin
        check_output("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
      end else begin
        e  = q.pop_front();
        oh = 4'b0001 << e.tag;
        check_output("rsp_owner", 64'(rsp_valid_o), 64'(oh));
        check_output("rsp_fp", 64'(rsp_fp_o), 64'(e.fp));
      end
    end
  end

  task automatic apply_stimulus(input logic [NR-1:0] valid, input bit fixed,
                                input logic [31:0] fa, input logic [31:0] fb);
    logic [NR-1:0] eg;
    int            g;
    @(negedge clk);
    check_output("mul_valid", 64'(mul_valid_o), 64'(prev_transfer));
    if (prev_transfer) begin
      check_output("mul_a", 64'(mul_a_o), 64'(prev_a));
      check_output("mul_b", 64'(mul_b_o), 64'(prev_b));
    end
    req_valid = valid;
    for (int i = 0; i < NR; i++) begin
      req_a[i*FW +: FW] = fixed ? fa : rand_fp();
      req_b[i*FW +: FW] = fixed ? fb : rand_fp();
    end
    #1;
    eg = model_grant(valid, model_ptr);
    check_output("req_ready", 64'(req_ready_o), 64'(eg));
    prev_transfer = (eg != '0);
    if (eg != '0) begin
      g = 0;
      for (int i = 0; i < NR; i++) if (eg[i]) g = i;
      prev_a = req_a[g*FW +: FW];
      prev_b = req_b[g*FW +: FW];
      q.push_back('{tag: g, fp: fp_mul(prev_a, prev_b)});
      model_ptr = (g + 1) % NR;
    end
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    req_valid = '0;
    #1;
    check_output("rst_mul_valid", 64'(mul_valid_o), 64'd0);
    check_output("rst_mul_a", 64'(mul_a_o), 64'd0);
    check_output("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_output("rst_rsp_fp", 64'(rsp_fp_o), 64'd0);
    check_output("rst_busy", 64'(busy_o), 64'd0);
    check_output("rst_error", 64'(error_o), 64'd0);
    check_output("rst_ready", 64'(req_ready_o), 64'd0);
    q.delete();
    model_ptr     = 0;
    prev_transfer = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (q.size() == 0) break;
      apply_stimulus('0, 1'b0, '0, '0);
    end
    check_output("drain_empty", 64'(q.size()), 64'd0);
    check_output("busy_last_rsp", 64'(busy_o), 64'd1);
    apply_stimulus('0, 1'b0, '0, '0);
    check_output("busy_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    inject        = 1'b0;
    req_a         = '0;
    req_b         = '0;
    model_ptr     = 0;
    prev_transfer = 1'b0;
    prev_a        = '0;
    prev_b        = '0;
    do_reset();

    $display("[TB] single request with exact latency");
    apply_stimulus(4'b0010, 1'b1, 32'h3FC00000, 32'h40000000);
    for (int k = 1; k <= L + 3; k++) begin
      apply_stimulus('0, 1'b0, '0, '0);
      check_output("rsp_valid_timing", 64'(rsp_valid_o), (k == L + 2) ? 64'h2 : 64'h0);
      if (k == L + 2) check_output("rsp_fp_1p5x2", 64'(rsp_fp_o), 64'h40400000);
      if (k == L + 3) check_output("busy_after_single", 64'(busy_o), 64'd0);
    end

    $display("[TB] full contention");
    for (int k = 0; k < 8; k++) apply_stimulus(4'b1111, 1'b0, '0, '0);
    drain();

    $display("[TB] pointer fairness");
    apply_stimulus(4'b0001, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) apply_stimulus(4'b1001, 1'b0, '0, '0);
    drain();

    $display("[TB] reset with traffic in flight");
    apply_stimulus(4'b0110, 1'b0, '0, '0);
    apply_stimulus(4'b0110, 1'b0, '0, '0);
    @(posedge clk);
    #2;
    do_reset();
    apply_stimulus(4'b0100, 1'b0, '0, '0);
    drain();

    $display("[TB] gapped issues");
    apply_stimulus(4'b0001, 1'b0, '0, '0);
    apply_stimulus(4'b0000, 1'b0, '0, '0);
    apply_stimulus(4'b1000, 1'b0, '0, '0);
    apply_stimulus(4'b0000, 1'b0, '0, '0);
    apply_stimulus(4'b0100, 1'b0, '0, '0);
    drain();

    $display("[TB] tag mismatch");
    check_output("error_before", 64'(error_o), 64'd0);
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    apply_stimulus('0, 1'b0, '0, '0);
    check_output("error_set", 64'(error_o), 64'd1);
    check_output("error_no_rsp", 64'(rsp_valid_o), 64'd0);
    for (int k = 0; k < 3; k++) apply_stimulus('0, 1'b0, '0, '0);
    check_output("error_sticky", 64'(error_o), 64'd1);
    @(posedge clk);
    #2;
    do_reset();
    apply_stimulus(4'b1111, 1'b0, '0, '0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
